// File: rtl/mult_div_if.sv
// Request/response bundle between the controller datapath and the
// iterative multiply/divide unit.
interface mult_div_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [5:0]       Funct;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;

  modport master (
    output Start, Funct, A, B,
    input  Busy, Done, Hi, Lo
  );

  modport slave (
    input  Start, Funct, A, B,
    output Busy, Done, Hi, Lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO.
// One bit per cycle; signed ops run on magnitudes and fix up at the end.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic      clk,
  input  logic      reset,
  mult_div_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1a;
  localparam logic [5:0] F_DIVU  = 6'h1b;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MTLO  = 6'h13;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               isdiv_q, isdiv_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;

  logic             f_mul, f_div, f_sgn;
  logic             f_mthi, f_mtlo, b_zero;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem, quo;
  logic [2*WIDTH-1:0] prod_neg;

  assign f_mul  = (bus.Funct == F_MULT) ||
                  (bus.Funct == F_MULTU);
  assign f_div  = (bus.Funct == F_DIV) ||
                  (bus.Funct == F_DIVU);
  assign f_sgn  = (bus.Funct == F_MULT) ||
                  (bus.Funct == F_DIV);
  assign f_mthi = (bus.Funct == F_MTHI);
  assign f_mtlo = (bus.Funct == F_MTLO);
  assign b_zero = (bus.B == '0);

  assign a_neg = f_sgn & bus.A[WIDTH-1];
  assign b_neg = f_sgn & bus.B[WIDTH-1];
  assign a_mag = a_neg ? -bus.A : bus.A;
  assign b_mag = b_neg ? -bus.B : bus.B;

  // Upper half accumulates; multiplier bits shift out of the bottom.
  assign msum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                {1'b0, prod_q[0] ? opb_q : '0};

  // Divide: upper half is remainder, lower half dividend/quotient.
  assign trial = {prod_q[2*WIDTH-1:WIDTH],
                  prod_q[WIDTH-1]} -
                 {1'b0, opb_q};

  assign rem      = prod_q[2*WIDTH-1:WIDTH];
  assign quo      = prod_q[WIDTH-1:0];
  assign prod_neg = -prod_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    prod_d  = prod_q;
    opb_d   = opb_q;
    isdiv_d = isdiv_q;
    negq_d  = negq_q;
    negr_d  = negr_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          unique case (1'b1)
            f_mul: begin
              prod_d  = {{WIDTH{1'b0}}, b_mag};
              opb_d   = a_mag;
              negq_d  = a_neg ^ b_neg;
              negr_d  = 1'b0;
              isdiv_d = 1'b0;
              busy_d  = 1'b1;
              cnt_d   = '0;
              state_d = S_MUL;
            end
            f_div && !b_zero: begin
              prod_d  = {{WIDTH{1'b0}}, a_mag};
              opb_d   = b_mag;
              negq_d  = a_neg ^ b_neg;
              negr_d  = a_neg;
              isdiv_d = 1'b1;
              busy_d  = 1'b1;
              cnt_d   = '0;
              state_d = S_DIV;
            end
            f_div && b_zero: begin
              hi_d   = bus.A;
              lo_d   = '1;
              done_d = 1'b1;
            end
            f_mthi: hi_d = bus.A;
            f_mtlo: lo_d = bus.A;
            default: ;
          endcase
        end
      end

      S_MUL: begin
        prod_d = {msum, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIX;
      end

      S_DIV: begin
        if (!trial[WIDTH])
          prod_d = {trial[WIDTH-1:0],
                    prod_q[WIDTH-2:0], 1'b1};
        else
          prod_d = {prod_q[2*WIDTH-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIX;
      end

      S_FIX: begin
        if (isdiv_q) begin
          lo_d = negq_q ? -quo : quo;
          hi_d = negr_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = negq_q ? prod_neg : prod_q;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
      opb_q   <= '0;
      isdiv_q <= 1'b0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      prod_q  <= prod_d;
      opb_q   <= opb_d;
      isdiv_q <= isdiv_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
    end
  end

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.Hi   = hi_q;
  assign bus.Lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed vector bench for mult_div_unit: result table plus
// hand-written handshake, stray-start and async-reset sequences.
module tb_mult_div_unit;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  mult_div_if #(.WIDTH(32)) bus ();

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          busy;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  // Entered at a negedge; returns at the negedge where Done is seen.
  task automatic run_op(input string nm,
                        input logic [5:0] f,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] eh,
                        input logic [31:0] el,
                        input int ebusy,
                        input bit stray);
    int bc;
    bit seen;
    bc = 0;
    seen = 0;
    bus.Start = 1'b1;
    bus.Funct = f;
    bus.A = a;
    bus.B = b;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      bus.Start = 1'b0;
      if (bus.Busy) bc++;
      if (bus.Done) seen = 1;
      else if (stray && bc == 5) begin
        bus.Start = 1'b1;
        bus.Funct = 6'h19;
        bus.A = 32'h9;
        bus.B = 32'h9;
      end
    end
    chk({nm, " done"}, 32'(seen), 32'd1);
    chk({nm, " hi"}, bus.Hi, eh);
    chk({nm, " lo"}, bus.Lo, el);
    chk({nm, " busy_cycles"}, 32'(bc), 32'(ebusy));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    bus.Start = 1'b0;
    bus.Funct = 6'h0;
    bus.A = '0;
    bus.B = '0;

    vecs[0] = '{"multu_max", 6'h19, 32'hFFFFFFFF,
                32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1, 33};
    vecs[1] = '{"mult_neg3x7", 6'h18, 32'hFFFFFFFD,
                32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 33};
    vecs[2] = '{"div_neg7by2", 6'h1a, 32'hFFFFFFF9,
                32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[3] = '{"divu_100by7", 6'h1b, 32'd100,
                32'd7, 32'd2, 32'd14, 33};
    vecs[4] = '{"div_minbyneg1", 6'h1a, 32'h80000000,
                32'hFFFFFFFF, 32'h0, 32'h80000000, 33};
    vecs[5] = '{"mult_minxmin", 6'h18, 32'h80000000,
                32'h80000000, 32'h40000000, 32'h0, 33};
    vecs[6] = '{"divu_by0", 6'h1b, 32'd5,
                32'd0, 32'd5, 32'hFFFFFFFF, 0};
    vecs[7] = '{"div_7byneg2", 6'h1a, 32'd7,
                32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33};
    vecs[8] = '{"multu_2p32", 6'h19, 32'h10000,
                32'h10000, 32'h1, 32'h0, 33};
    vecs[9] = '{"div_by0_neg", 6'h1a, 32'hFFFFFFF0,
                32'd0, 32'hFFFFFFF0, 32'hFFFFFFFF, 0};

    repeat (2) @(negedge clk);
    chk("rst busy", 32'(bus.Busy), 32'd0);
    chk("rst done", 32'(bus.Done), 32'd0);
    chk("rst hi", bus.Hi, 32'd0);
    chk("rst lo", bus.Lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].nm, vecs[i].f, vecs[i].a,
             vecs[i].b, vecs[i].hi, vecs[i].lo,
             vecs[i].busy, 1'b0);
      @(negedge clk);
      chk({vecs[i].nm, " done_pulse"},
          32'(bus.Done), 32'd0);
    end

    // mthi / mtlo: one-edge update, no Busy/Done
    bus.Start = 1'b1;
    bus.Funct = 6'h11;
    bus.A = 32'h12345678;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    @(negedge clk);
    chk("mthi hi", bus.Hi, 32'h12345678);
    chk("mthi busy", 32'(bus.Busy), 32'd0);
    chk("mthi done", 32'(bus.Done), 32'd0);
    bus.Start = 1'b1;
    bus.Funct = 6'h13;
    bus.A = 32'h9ABCDEF0;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    @(negedge clk);
    chk("mtlo lo", bus.Lo, 32'h9ABCDEF0);
    chk("mtlo hi", bus.Hi, 32'h12345678);
    chk("mtlo busy", 32'(bus.Busy), 32'd0);
    chk("mtlo done", 32'(bus.Done), 32'd0);

    // stray Start mid-mult must be ignored
    run_op("mult_stray", 6'h18, 32'd6, 32'd7,
           32'd0, 32'd42, 33, 1'b1);

    // new Start in the Done cycle is accepted
    bus.Start = 1'b1;
    bus.Funct = 6'h13;
    bus.A = 32'h55;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    @(negedge clk);
    chk("b2b lo", bus.Lo, 32'h55);
    chk("b2b done", 32'(bus.Done), 32'd0);

    // async reset mid divide
    bus.Start = 1'b1;
    bus.Funct = 6'h1b;
    bus.A = 32'd1000;
    bus.B = 32'd3;
    @(posedge clk);
    #1;
    bus.Start = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid busy", 32'(bus.Busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst busy", 32'(bus.Busy), 32'd0);
    chk("arst hi", bus.Hi, 32'd0);
    chk("arst lo", bus.Lo, 32'd0);
    chk("arst done", 32'(bus.Done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post busy", 32'(bus.Busy), 32'd0);
    chk("post lo", bus.Lo, 32'd0);

    run_op("divu_9by3", 6'h1b, 32'd9, 32'd3,
           32'd0, 32'd3, 33, 1'b0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the multi-cycle MIPS datapath, with its own HI/LO registers.
- Sits downstream of the controller/ALU-control stage and is driven when an R-type instruction (OpCode 6'h00, ALUOp FUNCT) carries a mult/div/mthi/mtlo Funct.
- Takes operands from the A/B registers.
- Raises Busy while iterating; the controller holds in its execute state until Done.

Parameters:
WIDTH, 32, operand and HI/LO width
CNT_W, 6, iteration counter width (must hold WIDTH)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
Start  input  1  one-cycle request, sampled only in IDLE
Funct  input  6  6'h18 mult, 6'h19 multu, 6'h1a div, 6'h1b divu, 6'h11 mthi, 6'h13 mtlo
A  input  WIDTH  rs operand (dividend / multiplicand / mthi-mtlo source)
B  input  WIDTH  rt operand (divisor / multiplier)
Busy  output  1  operation in progress
Done  output  1  one-cycle pulse: Hi/Lo just updated by mult/div
Hi  output  WIDTH  HI register
Lo  output  WIDTH  LO register

Behaviour:
- Reset (reset=0, async): state IDLE, Busy=0, Done=0, Hi=0, Lo=0, counter=0, internal accumulators=0. Reset mid-operation aborts it with no partial Hi/Lo write.
- States: IDLE, MUL, DIV, FIX.

IDLE:
- Start=1 with Funct 6'h18/6'h19 at edge E0:
  - latch operands; signed ops store magnitudes plus sign flags.
  - Busy<=1, counter<=0, go to MUL.
- Start=1 with Funct 6'h1a/6'h1b and B!=0: same, go to DIV.
- Start=1, div/divu, B==0 at E0:
  - Hi<=A, Lo<=all ones, Done<=1.
  - Busy stays 0, stay IDLE.
- Start=1, Funct 6'h11: Hi<=A at E0. Busy and Done stay 0.
- Start=1, Funct 6'h13: Lo<=A at E0. Busy and Done stay 0.
- Start=1 with any other Funct: ignored.
- Done is 0 in every cycle in which it is not explicitly pulsed.

MUL (shift-add, one multiplier bit per cycle):
- 2*WIDTH-bit product register.
- counter increments each cycle.
- After WIDTH iterations (edges E1..E32), go to FIX.

DIV (restoring, one quotient bit per cycle):
- WIDTH-bit remainder, WIDTH-bit quotient.
- After WIDTH iterations (E1..E32), go to FIX.

FIX (edge E33):
- mult: {Hi,Lo}<=product, two's-complement negated if the sign flags differ (signed only).
- div:
  - Lo<=quotient, negated if the operand signs differ (signed only).
  - Hi<=remainder, taking the dividend's sign (signed only).
- Done<=1, Busy<=0, go to IDLE.

Latency and handshake:
- Busy high for exactly 33 cycles after E0.
- Done visible in the cycle after E33.
- Start while Busy=1 is ignored; operands and Funct are not re-sampled.
- A new Start may be issued in the same cycle Done is high; it is accepted.
- Hi/Lo are stable and readable at all times. They change only at E0 (mthi/mtlo/div-by-0) or at FIX.

Boundaries:
- div 0x80000000 / 0xFFFFFFFF (signed): Lo=0x80000000, Hi=0.
- mult 0x80000000 * 0x80000000 (signed): {Hi,Lo}=0x4000000000000000.
- multu 0xFFFFFFFF * 0xFFFFFFFF: Hi=0xFFFFFFFE, Lo=0x00000001.

Test Plan:
- Reset then multu A=0xFFFFFFFF, B=0xFFFFFFFF: Busy high 33 cycles, then Done pulse; Hi=0xFFFFFFFE, Lo=0x00000001.
- mult A=0xFFFFFFFD (-3), B=7: Hi=0xFFFFFFFF, Lo=0xFFFFFFEB (-21) at Done.
- div A=0xFFFFFFF9 (-7), B=2: Lo=0xFFFFFFFD (-3), Hi=0xFFFFFFFF (-1).
- divu A=100, B=7: Lo=14, Hi=2.
- div A=0x80000000, B=0xFFFFFFFF: Lo=0x80000000, Hi=0.
- divu A=5, B=0: Done next cycle, Busy never high; Hi=5, Lo=0xFFFFFFFF.
- mthi A=0x12345678 then mtlo A=0x9ABCDEF0: Hi and Lo update one edge after each Start; Busy=0, Done=0 throughout.
- Start asserted again mid-mult with different operands: ignored, original result delivered.
- reset=0 at iteration 10 of a div: Busy=0, Hi=Lo=0 immediately (asynchronous).
- After reset release, divu 9/3 gives Lo=3, Hi=0.
